// File: rtl/output_writeback.sv
// Collects convolution results into PACK-lane words, queues them in a small FIFO,
// and writes them to the output SRAM. Optional counters: OUTPUT_WRITEBACK_STATS_EN.
module output_writeback #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int PACK               = 4,
  parameter int FIFO_DEPTH         = 8,
  parameter int ADDR_WIDTH         = 20
) (
  input  logic                                    clk,
  input  logic                                    arst,
  input  logic                                    in_valid,
  input  logic signed [DATA_WIDTH-1:0]            in_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   in_ch,
  input  logic                                    start,
  input  logic                                    flush,
  output logic                                    mem_valid,
  input  logic                                    mem_ready,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  output logic [PACK*DATA_WIDTH-1:0]              mem_wdata,
  output logic [PACK-1:0]                         mem_wmask,
  output logic                                    busy,
  output logic                                    overflow
`ifdef OUTPUT_WRITEBACK_STATS_EN
  ,
  output logic [31:0]                             stat_words,
  output logic [31:0]                             stat_partial
`endif
);

  localparam int LOG2P = $clog2(PACK);
  localparam int LW    = $clog2(FIFO_DEPTH);
  localparam int PW    = ADDR_WIDTH + LOG2P;
  localparam int WW    = PACK * DATA_WIDTH;

  // Collector; empty exactly when its mask is zero. Unset lanes are kept at zero.
  logic [ADDR_WIDTH-1:0] r_col_addr;
  logic [WW-1:0]         r_col_data;
  logic [PACK-1:0]       r_col_mask;
  logic                  r_flush_pend;

  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [WW-1:0]         r_fifo_data [FIFO_DEPTH];
  logic [PACK-1:0]       r_fifo_mask [FIFO_DEPTH];
  logic [LW:0]           r_wp;
  logic [LW:0]           r_rp;
  logic                  r_overflow;

  logic [PW-1:0]         w_lin;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [LOG2P-1:0]      w_lane;
  logic                  w_col_empty;
  logic                  w_flush_req;
  logic [WW-1:0]         w_samp_data;
  logic [PACK-1:0]       w_samp_mask;
  logic [WW-1:0]         w_merge_data;
  logic [PACK-1:0]       w_merge_mask;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic [WW-1:0]         w_push_data;
  logic [PACK-1:0]       w_push_mask;
  logic [ADDR_WIDTH-1:0] w_col_addr_n;
  logic [WW-1:0]         w_col_data_n;
  logic [PACK-1:0]       w_col_mask_n;
  logic                  w_pend_n;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;

  assign w_lin = ((PW'(in_y) * PW'(FEATURE_MAP_WIDTH)) + PW'(in_x)) * PW'(OUTPUT_NB_CHANNELS)
                 + PW'(in_ch);
  assign w_waddr     = ADDR_WIDTH'(w_lin >> LOG2P);
  assign w_lane      = w_lin[LOG2P-1:0];
  assign w_col_empty = (r_col_mask == '0);
  assign w_flush_req = flush | r_flush_pend;

  always_comb begin
    w_samp_data  = '0;
    w_samp_mask  = '0;
    w_merge_data = w_col_empty ? '0 : r_col_data;
    w_merge_mask = w_col_empty ? '0 : r_col_mask;
    for (int k = 0; k < PACK; k++) begin
      if (w_lane == LOG2P'(k)) begin
        w_samp_data[k*DATA_WIDTH +: DATA_WIDTH]  = in_data;
        w_samp_mask[k]                           = 1'b1;
        w_merge_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        w_merge_mask[k]                          = 1'b1;
      end
    end
  end

  // One push per cycle: a word-change push defers a same-cycle flush by one cycle.
  always_comb begin
    w_push       = 1'b0;
    w_push_addr  = r_col_addr;
    w_push_data  = r_col_data;
    w_push_mask  = r_col_mask;
    w_col_addr_n = r_col_addr;
    w_col_data_n = r_col_data;
    w_col_mask_n = r_col_mask;
    w_pend_n     = 1'b0;
    if (in_valid) begin
      if (w_col_empty || (w_waddr == r_col_addr && !r_col_mask[w_lane])) begin
        if ((&w_merge_mask) || w_flush_req) begin
          w_push       = 1'b1;
          w_push_addr  = w_waddr;
          w_push_data  = w_merge_data;
          w_push_mask  = w_merge_mask;
          w_col_data_n = '0;
          w_col_mask_n = '0;
        end else begin
          w_col_addr_n = w_waddr;
          w_col_data_n = w_merge_data;
          w_col_mask_n = w_merge_mask;
        end
      end else begin
        w_push       = 1'b1;
        w_col_addr_n = w_waddr;
        w_col_data_n = w_samp_data;
        w_col_mask_n = w_samp_mask;
        w_pend_n     = w_flush_req;
      end
    end else if (w_flush_req && !w_col_empty) begin
      w_push       = 1'b1;
      w_col_data_n = '0;
      w_col_mask_n = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_col_addr   <= '0;
      r_col_data   <= '0;
      r_col_mask   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_col_addr   <= w_col_addr_n;
      r_col_data   <= w_col_data_n;
      r_col_mask   <= w_col_mask_n;
      r_flush_pend <= w_pend_n;
    end
  end

  // A same-cycle pop frees the slot for a push even when full.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[LW] != r_rp[LW]) && (r_wp[LW-1:0] == r_rp[LW-1:0]);
  assign w_pop   = !w_empty && mem_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_fifo_addr[r_wp[LW-1:0]] <= w_push_addr;
      r_fifo_data[r_wp[LW-1:0]] <= w_push_data;
      r_fifo_mask[r_wp[LW-1:0]] <= w_push_mask;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + (LW+1)'(1);
      if (w_pop) r_rp <= r_rp + (LW+1)'(1);
      if (w_drop)      r_overflow <= 1'b1;
      else if (start)  r_overflow <= 1'b0;
    end
  end

  assign mem_valid = !w_empty;
  assign mem_addr  = w_empty ? '0 : r_fifo_addr[r_rp[LW-1:0]];
  assign mem_wdata = w_empty ? '0 : r_fifo_data[r_rp[LW-1:0]];
  assign mem_wmask = w_empty ? '0 : r_fifo_mask[r_rp[LW-1:0]];
  assign busy      = !w_col_empty || !w_empty || r_flush_pend;
  assign overflow  = r_overflow;

`ifdef OUTPUT_WRITEBACK_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_partial;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stat_words   <= '0;
      r_stat_partial <= '0;
    end else if (start) begin
      r_stat_words   <= '0;
      r_stat_partial <= '0;
    end else if (w_pop) begin
      if (r_stat_words != '1) r_stat_words <= r_stat_words + 32'd1;
      if (!(&mem_wmask) && r_stat_partial != '1) r_stat_partial <= r_stat_partial + 32'd1;
    end
  end

  assign stat_words   = r_stat_words;
  assign stat_partial = r_stat_partial;
`endif

endmodule

// File: tb/tb_output_writeback.sv
// Directed bench for output_writeback: per-cycle vector table plus hand-written
// sequences for FIFO overflow, asynchronous reset and the optional counters.
module tb_output_writeback;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [6:0]  in_x;
  logic [6:0]  in_y;
  logic [5:0]  in_ch;
  logic        start;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [19:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        busy;
  logic        overflow;
`ifdef OUTPUT_WRITEBACK_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_partial;
`endif

  output_writeback dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .start(start), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .busy(busy), .overflow(overflow)
`ifdef OUTPUT_WRITEBACK_STATS_EN
    , .stat_words(stat_words), .stat_partial(stat_partial)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;
  logic mon_en = 1'b0;
  logic [87:0] exp_q[$];

  typedef struct {
    logic        v;
    int          x, y, ch, d;
    logic        fl;
    logic        e_mv;
    logic [19:0] e_addr;
    logic [63:0] e_wdata;
    logic [3:0]  e_mask;
    logic        e_busy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic v, input int x, input int y, input int ch, input int d,
                              input logic fl, input logic e_mv, input logic [19:0] e_addr,
                              input logic [63:0] e_wdata, input logic [3:0] e_mask,
                              input logic e_busy);
    vec_t r;
    r.v = v; r.x = x; r.y = y; r.ch = ch; r.d = d; r.fl = fl;
    r.e_mv = e_mv; r.e_addr = e_addr; r.e_wdata = e_wdata; r.e_mask = e_mask; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("%s FAIL got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic v, input int x, input int y, input int ch, input int d,
                     input logic fl, input logic st);
    in_valid = v; in_x = 7'(x); in_y = 7'(y); in_ch = 6'(ch); in_data = 16'(d);
    flush = fl; start = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0; start = 1'b0;
  endtask

  // Memory-side scoreboard: a handshake at the next edge is visible at the falling edge.
  always @(negedge clk) begin
    if (mon_en && mem_valid && mem_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("wr_extra FAIL got write addr %0h mask %0h, expected no write", mem_addr, mem_wmask);
      end else begin
        chk("wr_word", {8'h0, mem_addr, mem_wmask, mem_wdata}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int snap;
    logic [63:0] w;
    arst = 1'b1; in_valid = 0; in_data = 0; in_x = 0; in_y = 0; in_ch = 0;
    start = 0; flush = 0; mem_ready = 1'b1;
    #1;
    chk("rst_mv", 96'(mem_valid), 96'(0));
    chk("rst_addr", 96'(mem_addr), 96'(0));
    chk("rst_wdata", 96'(mem_wdata), 96'(0));
    chk("rst_mask", 96'(mem_wmask), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_ovf", 96'(overflow), 96'(0));
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    tbl[0]  = mk(1, 0, 0, 0, 1,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[1]  = mk(1, 0, 0, 1, 2,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[2]  = mk(1, 0, 0, 2, 3,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[3]  = mk(1, 0, 0, 3, 4,     0, 1, 0,    64'h0004_0003_0002_0001, 4'hf, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0,     0, 0, 0,    64'h0, 4'h0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 'h11,  0, 0, 0,    64'h0, 4'h0, 1);
    tbl[6]  = mk(1, 0, 0, 1, 'h22,  0, 0, 0,    64'h0, 4'h0, 1);
    tbl[7]  = mk(1, 1, 0, 0, 'h33,  0, 1, 0,    64'h0000_0000_0022_0011, 4'h3, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0,     1, 1, 16,   64'h33, 4'h1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0,     0, 0, 0,    64'h0, 4'h0, 0);
    tbl[10] = mk(1, 0, 1, 0, 5,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[11] = mk(1, 0, 1, 1, 6,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[12] = mk(1, 0, 1, 2, 7,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[13] = mk(1, 0, 1, 3, 8,     1, 1, 2048, 64'h0008_0007_0006_0005, 4'hf, 1);
    tbl[14] = mk(0, 0, 0, 0, 0,     0, 0, 0,    64'h0, 4'h0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,     1, 0, 0,    64'h0, 4'h0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0,     0, 0, 0,    64'h0, 4'h0, 0);
    tbl[17] = mk(1, 0, 0, 4, 9,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[18] = mk(1, 0, 0, 8, 'hA,   1, 1, 1,    64'h9, 4'h1, 1);
    tbl[19] = mk(0, 0, 0, 0, 0,     0, 1, 2,    64'hA, 4'h1, 1);
    tbl[20] = mk(0, 0, 0, 0, 0,     0, 0, 0,    64'h0, 4'h0, 0);
    tbl[21] = mk(1, 0, 0, 0, 1,     0, 0, 0,    64'h0, 4'h0, 1);
    tbl[22] = mk(1, 0, 0, 0, 2,     0, 1, 0,    64'h1, 4'h1, 1);
    tbl[23] = mk(0, 0, 0, 0, 0,     1, 1, 0,    64'h2, 4'h1, 1);
    tbl[24] = mk(0, 0, 0, 0, 0,     0, 0, 0,    64'h0, 4'h0, 0);

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].ch, tbl[i].d, tbl[i].fl, 1'b0);
      chk($sformatf("row%0d_mv", i),    96'(mem_valid), 96'(tbl[i].e_mv));
      chk($sformatf("row%0d_addr", i),  96'(mem_addr),  96'(tbl[i].e_addr));
      chk($sformatf("row%0d_wdata", i), 96'(mem_wdata), 96'(tbl[i].e_wdata));
      chk($sformatf("row%0d_mask", i),  96'(mem_wmask), 96'(tbl[i].e_mask));
      chk($sformatf("row%0d_busy", i),  96'(busy),      96'(tbl[i].e_busy));
      chk($sformatf("row%0d_ovf", i),   96'(overflow),  96'(0));
    end

    // Nine complete words into an eight-deep FIFO with the memory stalled.
    mem_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int l = 0; l < 4; l++) begin
        w[l*16 +: 16] = 16'(k*16 + l);
        cyc(1, 0, 0, 4*k + l, k*16 + l, 0, 0);
      end
      if (k < 8) exp_q.push_back({20'(k), 4'hf, w});
    end
    chk("ovf_set", 96'(overflow), 96'(1));
    chk("stall_mv", 96'(mem_valid), 96'(1));
    chk("stall_addr0", 96'(mem_addr), 96'(0));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("stall_addr1", 96'(mem_addr), 96'(0));
    chk("stall_wdata", 96'(mem_wdata), 96'(64'h0003_0002_0001_0000));
    snap = n_writes;
    mon_en = 1'b1;
    mem_ready = 1'b1;
    repeat (12) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drain_count", 96'(n_writes - snap), 96'(8));
    chk("drain_q_empty", 96'(exp_q.size()), 96'(0));
    chk("drain_busy", 96'(busy), 96'(0));
    chk("ovf_sticky", 96'(overflow), 96'(1));
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ovf_start", 96'(overflow), 96'(0));

    // Reset while words are queued and a partial word sits in the collector.
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 4; l++) cyc(1, 0, 0, 4*k + l, 100 + l, 0, 0);
    cyc(1, 0, 0, 12, 7, 0, 0);
    chk("pre_rst_mv", 96'(mem_valid), 96'(1));
    chk("pre_rst_busy", 96'(busy), 96'(1));
    #2 arst = 1'b1;
    #1;
    chk("arst_mv", 96'(mem_valid), 96'(0));
    chk("arst_busy", 96'(busy), 96'(0));
    chk("arst_addr", 96'(mem_addr), 96'(0));
    chk("arst_wdata", 96'(mem_wdata), 96'(0));
    chk("arst_mask", 96'(mem_wmask), 96'(0));
    @(posedge clk);
    #1 arst = 1'b0;
    snap = n_writes;
    mem_ready = 1'b1;
    repeat (8) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_writes", 96'(n_writes - snap), 96'(0));
    chk("post_rst_busy", 96'(busy), 96'(0));

    // Two partial words through the scoreboard; also feeds the optional counters.
    exp_q.push_back({20'd0, 4'h3, 64'h0000_0000_0022_0011});
    exp_q.push_back({20'd16, 4'h1, 64'h0000_0000_0000_0033});
    snap = n_writes;
    cyc(1, 0, 0, 0, 'h11, 0, 0);
    cyc(1, 0, 0, 1, 'h22, 0, 0);
    cyc(1, 1, 0, 0, 'h33, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("s2_writes", 96'(n_writes - snap), 96'(2));
    chk("s2_busy", 96'(busy), 96'(0));
`ifdef OUTPUT_WRITEBACK_STATS_EN
    chk("stat_words", 96'(stat_words), 96'(2));
    chk("stat_partial", 96'(stat_partial), 96'(2));
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("stat_words_clr", 96'(stat_words), 96'(0));
    chk("stat_partial_clr", 96'(stat_partial), 96'(0));
`endif
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
